// File: rtl/coax_rx_holdoff_if.sv
// Signal bundle between the coax receive front end and the holdoff blanker.
// The master side drives line/control inputs; the slave (the blanker) drives the filtered line and status.
interface coax_rx_holdoff_if #(
  parameter int HOLDOFF_WIDTH    = 8,
  parameter int EDGE_COUNT_WIDTH = 8
) ();
  logic                        enable;
  logic                        rx_input;
  logic                        tx_active;
  logic [HOLDOFF_WIDTH-1:0]    holdoff_clocks;
  logic                        count_clear;
  logic                        rx_output;
  logic                        blanking;
  logic [EDGE_COUNT_WIDTH-1:0] blanked_edges;

  modport master (
    output enable, rx_input, tx_active, holdoff_clocks, count_clear,
    input  rx_output, blanking, blanked_edges
  );

  modport slave (
    input  enable, rx_input, tx_active, holdoff_clocks, count_clear,
    output rx_output, blanking, blanked_edges
  );
endinterface

// File: rtl/coax_rx_holdoff.sv
// Receive blanker: masks rx while the local transmitter is active plus a programmable holdoff.
// Define COAX_RX_HOLDOFF_QUIET_EN to also wait for QUIET_CLOCKS consecutive low samples before release.
module coax_rx_holdoff #(
  parameter int HOLDOFF_WIDTH    = 8,
  parameter int QUIET_CLOCKS     = 4,
  parameter int EDGE_COUNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  coax_rx_holdoff_if.slave  bus
);

  if (QUIET_CLOCKS < 1) begin : g_bad_quiet_clocks
    $error("coax_rx_holdoff: QUIET_CLOCKS must be at least 1");
  end

`ifdef COAX_RX_HOLDOFF_QUIET_EN
  localparam int QW = $clog2(QUIET_CLOCKS + 1);
  typedef enum logic [1:0] {S_IDLE, S_TX, S_HOLDOFF, S_QUIET} state_t;
  localparam state_t S_RELEASE = S_QUIET;
`else
  typedef enum logic [1:0] {S_IDLE, S_TX, S_HOLDOFF} state_t;
  localparam state_t S_RELEASE = S_IDLE;
`endif

  state_t                      state, state_nxt;
  logic [HOLDOFF_WIDTH-1:0]    cnt, cnt_nxt;
`ifdef COAX_RX_HOLDOFF_QUIET_EN
  logic [QW-1:0]               q, q_nxt;
`endif
  logic                        rx_d0, rx_d1, enable_d0;
  logic                        blanking_q, rx_output_q;
  logic [EDGE_COUNT_WIDTH-1:0] edges_q;
  logic                        edge_hit;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
`ifdef COAX_RX_HOLDOFF_QUIET_EN
      q     <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
`ifdef COAX_RX_HOLDOFF_QUIET_EN
      q     <= q_nxt;
`endif
    end
  end

  // Next state; tx_active overrides everything, so a 1-cycle pulse still runs a full sequence.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef COAX_RX_HOLDOFF_QUIET_EN
    q_nxt     = q;
`endif
    if (bus.tx_active) begin
      state_nxt = S_TX;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_IDLE;
        S_TX: begin
          if (bus.holdoff_clocks != '0) begin
            state_nxt = S_HOLDOFF;
            cnt_nxt   = bus.holdoff_clocks;
          end else begin
            state_nxt = S_RELEASE;
`ifdef COAX_RX_HOLDOFF_QUIET_EN
            q_nxt     = '0;
`endif
          end
        end
        S_HOLDOFF: begin
          if (cnt == HOLDOFF_WIDTH'(1)) begin
            state_nxt = S_RELEASE;
`ifdef COAX_RX_HOLDOFF_QUIET_EN
            q_nxt     = '0;
`endif
          end else begin
            cnt_nxt = cnt - HOLDOFF_WIDTH'(1);
          end
        end
`ifdef COAX_RX_HOLDOFF_QUIET_EN
        S_QUIET: begin
          if (rx_d0) begin
            q_nxt = '0;
          end else if (q == QW'(QUIET_CLOCKS - 1)) begin
            state_nxt = S_IDLE;
            q_nxt     = '0;
          end else begin
            q_nxt = q + QW'(1);
          end
        end
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Input pipeline; enable is delayed so it lines up with rx_d0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_d0     <= 1'b0;
      rx_d1     <= 1'b0;
      enable_d0 <= 1'b0;
    end else begin
      rx_d0     <= bus.rx_input;
      rx_d1     <= rx_d0;
      enable_d0 <= bus.enable;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blanking_q  <= 1'b0;
      rx_output_q <= 1'b0;
    end else begin
      blanking_q  <= (state_nxt != S_IDLE);
      rx_output_q <= (enable_d0 && blanking_q) ? 1'b0 : rx_d0;
    end
  end

  assign edge_hit = blanking_q && enable_d0 && rx_d0 && !rx_d1;

  // Saturating suppressed-edge counter; clear beats a coincident edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edges_q <= '0;
    end else if (bus.count_clear) begin
      edges_q <= '0;
    end else if (edge_hit && (edges_q != '1)) begin
      edges_q <= edges_q + EDGE_COUNT_WIDTH'(1);
    end
  end

  assign bus.blanking      = blanking_q;
  assign bus.rx_output     = rx_output_q;
  assign bus.blanked_edges = edges_q;

endmodule

// File: tb/tb_coax_rx_holdoff.sv
// Scoreboard bench for coax_rx_holdoff: directed vectors push expected outputs, a monitor pops and compares.
module tb_coax_rx_holdoff;

  localparam int HW  = 8;
  localparam int QC  = 4;
  localparam int ECW = 2;

  localparam logic [2:0] M_ALL = 3'b111;
  localparam logic [2:0] M_RB  = 3'b110;

  typedef struct {
    string      tag;
    logic [2:0] m;
    logic       xr;
    logic       xb;
    logic [1:0] xe;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  coax_rx_holdoff_if #(.HOLDOFF_WIDTH(HW), .EDGE_COUNT_WIDTH(ECW)) bus_if ();

  coax_rx_holdoff #(
    .HOLDOFF_WIDTH(HW), .QUIET_CLOCKS(QC), .EDGE_COUNT_WIDTH(ECW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s actual=%0d required=%0d", tag, fld, act, exp);
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.m[2]) chk(e.tag, "rx_output", {1'b0, bus_if.rx_output}, {1'b0, e.xr});
      if (e.m[1]) chk(e.tag, "blanking", {1'b0, bus_if.blanking}, {1'b0, e.xb});
      if (e.m[0]) chk(e.tag, "blanked_edges", bus_if.blanked_edges, e.xe);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string tag, input logic rn, input logic en, input logic rx, input logic tx,
                      input logic [HW-1:0] ho, input logic clr, input logic [2:0] m,
                      input logic xr, input logic xb, input logic [1:0] xe);
    exp_t e;
    reset_n               = rn;
    bus_if.enable         = en;
    bus_if.rx_input       = rx;
    bus_if.tx_active      = tx;
    bus_if.holdoff_clocks = ho;
    bus_if.count_clear    = clr;
    e.tag = tag; e.m = m; e.xr = xr; e.xb = xb; e.xe = xe;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:6]  p_rx, p_xr;
    logic [1:12] h_rx, h_tx, h_xr, h_xb;
    logic [1:13] w_rx, w_clr;
    logic [1:10] a_tx, a_xb;
    int          w_xe[13];
    int          a_ho[10];
    n_chk = 0;
    n_pass = 0;

    step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, M_ALL, 1'b0, 1'b0, 2'd0);
    step("reset", 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, M_ALL, 1'b0, 1'b0, 2'd0);

    // Pass-through with blanking disabled: output is the input one registered stage later.
    p_rx = 6'b101100;
    p_xr = 6'b010110;
    for (int i = 1; i <= 6; i++)
      step("pass", 1'b1, 1'b0, p_rx[i], 1'b0, 8'd0, 1'b0, M_ALL, p_xr[i], 1'b0, 2'd0);

`ifndef COAX_RX_HOLDOFF_QUIET_EN
    // tx high 5 cycles, holdoff 3, input toggling.
    step("hold_pre", 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, M_RB, 1'b0, 1'b0, 2'd0);
    h_rx = 12'b101010101010;
    h_tx = 12'b111110000000;
    h_xr = 12'b000000000101;
    h_xb = 12'b111111110000;
    for (int i = 1; i <= 12; i++)
      step("hold3", 1'b1, 1'b1, h_rx[i], h_tx[i], 8'd3, 1'b0, M_RB, h_xr[i], h_xb[i], 2'd0);

    // Zero holdoff: blanking drops one edge after tx falls.
    step("hold0", 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("hold0", 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("hold0", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, M_RB, 1'b0, 1'b0, 2'd0);
    step("hold0", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, M_RB, 1'b0, 1'b0, 2'd0);
`else
    // Holdoff 2 then quiet wait; line high for two samples restarts the quiet count.
    step("quiet", 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("quiet", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("quiet", 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("quiet", 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("quiet", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("quiet", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("quiet", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("quiet", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, M_RB, 1'b0, 1'b1, 2'd0);
    step("quiet", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, M_RB, 1'b0, 1'b0, 2'd0);
    step("quiet", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, M_RB, 1'b0, 1'b0, 2'd0);
`endif

    // Edge counter: 5 edges saturate a 2-bit count, clear wins over the 6th edge.
    step("edges", 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, M_ALL, 1'b0, 1'b1, 2'd0);
    w_rx  = 13'b1010101010100;
    w_clr = 13'b0000000000010;
    w_xe  = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 0, 0};
    for (int i = 1; i <= 13; i++)
      step("edges", 1'b1, 1'b1, w_rx[i], 1'b1, 8'd0, w_clr[i], M_ALL, 1'b0, 1'b1, 2'(w_xe[i-1]));

    // Abort mid-holdoff; holdoff changes while counting are ignored, reloaded at the next fall.
    a_tx = 10'b0010000000;
    a_ho = '{4, 1, 1, 2, 7, 7, 7, 7, 7, 7};
`ifndef COAX_RX_HOLDOFF_QUIET_EN
    a_xb = 10'b1111100000;
`else
    a_xb = 10'b1111111110;
`endif
    for (int i = 1; i <= 10; i++)
      step("abort", 1'b1, 1'b1, 1'b0, a_tx[i], HW'(a_ho[i-1]), 1'b0, M_ALL, 1'b0, a_xb[i], 2'd0);

    // Reset in TX with a non-zero count and a pending high output.
    step("rst_mid", 1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 1'b0, M_ALL, 1'b0, 1'b1, 2'd0);
    step("rst_mid", 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, M_ALL, 1'b0, 1'b1, 2'd1);
    step("rst_mid", 1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 1'b0, M_ALL, 1'b0, 1'b1, 2'd1);
    step("rst_mid", 1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 1'b0, M_ALL, 1'b0, 1'b0, 2'd0);
    step("rst_post", 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, M_ALL, 1'b0, 1'b0, 2'd0);
    step("rst_post", 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, M_ALL, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
